bit_normalizer: RTL

- Sequential normalizer: accepts a 32-bit word and shifts it until the leading '1' reaches the selected boundary, reporting the normalized word and the shift count consumed.
- Performs the inverse of barrel shifting: it discovers the shift amount instead of applying one.
- Sits beside the barrel shifter in the lab2 datapath and feeds normalized operands plus shift amounts to downstream arithmetic.
- Uses valid/ready handshakes on both sides and shares the direction type with the shifter through `pkg`.

---
 rtl/pkg.sv | 30 +++
 rtl/bit_normalizer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pkg.sv
// ============================================================================
//  Module      : pkg
//  Description : Types and constants shared by the lab2 shifter datapath.
//                The barrel shifter and the bit normalizer both use the
//                direction type declared here.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkg;

    // Shift direction, common to the barrel shifter and the normalizer
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } direction;

    // Normalizer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } norm_state_e;

    localparam int NORM_W     = 32;
    localparam int NORM_CNT_W = 5;

endpackage : pkg

`default_nettype wire

// File: rtl/bit_normalizer.sv
// ============================================================================
//  Module      : bit_normalizer
//  Description : Sequential normalizer. Shifts a 32-bit word until its
//                leading '1' (MSB side for LEFT, LSB side for RIGHT) reaches
//                the boundary bit, and reports the shift count consumed.
//                Valid/ready handshakes on input and output.
//                Optional macro BIT_NORMALIZER_FAST_EN enables 4-bit skip
//                steps over an all-zero boundary nibble.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_normalizer
    import pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NORM_W-1:0]     data_in,
    input  direction              left_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NORM_W-1:0]     data_out,
    output logic [NORM_CNT_W-1:0] shift_cnt,
    output logic                  zero
);

    norm_state_e           state_q, state_d;
    logic [NORM_W-1:0]     data_q, data_d;
    logic [NORM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  zero_q, zero_d;
    direction              dir_q, dir_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    // Next-state and shift-step logic; the working register doubles as the result
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    dir_d   = left_right;
                    cnt_d   = '0;
                    zero_d  = (data_in == '0);
                    state_d = (data_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (dir_q == LEFT) begin
                    if (data_q[NORM_W-1]) begin
                        state_d = DONE;
                    end
`ifdef BIT_NORMALIZER_FAST_EN
                    else if (data_q[NORM_W-1 -: 4] == 4'd0) begin
                        // Whole nibble is empty: skip it in one step
                        data_d = data_q << 4;
                        cnt_d  = cnt_q + NORM_CNT_W'(4);
                    end
`endif
                    else begin
                        data_d = data_q << 1;
                        cnt_d  = cnt_q + NORM_CNT_W'(1);
                    end
                end else begin
                    if (data_q[0]) begin
                        state_d = DONE;
                    end
`ifdef BIT_NORMALIZER_FAST_EN
                    else if (data_q[3:0] == 4'd0) begin
                        data_d = data_q >> 4;
                        cnt_d  = cnt_q + NORM_CNT_W'(4);
                    end
`endif
                    else begin
                        data_d = data_q >> 1;
                        cnt_d  = cnt_q + NORM_CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered, derived from the upcoming state
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, working register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            dir_q       <= LEFT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            dir_q       <= dir_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign shift_cnt = cnt_q;
    assign zero      = zero_q;

endmodule : bit_normalizer

`default_nettype wire
